// File: rtl/conware_gen_sequencer.sv
// conware_gen_sequencer: steps a Game-of-Life generation one row at a time.
// For each row it pulses row_start to the compute engine and waits for row_done.
// It then offers the row to the output packer on out_valid/out_ready.
// Optional build macro GEN_LIMIT_EN adds gen_limit/limit_hit, which stop the run
// after a programmed number of generations.
module conware_gen_sequencer #(
   parameter int HEIGHT = 64,
   parameter int RWIDTH = 8,
   parameter int GWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   input  logic              clear_gen,
   output logic [RWIDTH-1:0] row_addr,
   output logic              row_start,
   input  logic              row_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_done,
   output logic [GWIDTH-1:0] gen_count,
   output logic              busy
`ifdef GEN_LIMIT_EN
   ,
   input  logic [GWIDTH-1:0] gen_limit,
   output logic              limit_hit
`endif
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      COMPUTE   = 3'd2,
      DRAIN     = 3'd3,
      FRAME_END = 3'd4
   } state_t;

   localparam logic [RWIDTH-1:0] LAST_ROW = RWIDTH'(HEIGHT - 1);

   state_t            state_q, state_d;
   logic [RWIDTH-1:0] row_addr_q, row_addr_d;
   logic [GWIDTH-1:0] gen_count_q, gen_count_d;
   logic              step_mode_q, step_mode_d;

`ifdef GEN_LIMIT_EN
   // Compare one bit wider so a limit at the counter's wrap point is not matched early.
   logic limit_stop;
   assign limit_stop = (state_q == FRAME_END) && (gen_limit != '0) &&
                       (({1'b0, gen_count_q} + {{GWIDTH{1'b0}}, 1'b1}) == {1'b0, gen_limit});
   assign limit_hit  = limit_stop;
`endif

   // Next-state logic; row_done and out_ready are looked at only in their own states.
   always_comb begin
      state_d     = state_q;
      row_addr_d  = row_addr_q;
      gen_count_d = gen_count_q;
      step_mode_d = step_mode_q;
      case (state_q)
         IDLE: begin
            if (step) begin
               state_d     = ISSUE;
               row_addr_d  = '0;
               step_mode_d = 1'b1;
            end else if (run) begin
               state_d     = ISSUE;
               step_mode_d = 1'b0;
            end
         end
         ISSUE:   state_d = COMPUTE;
         COMPUTE: if (row_done) state_d = DRAIN;
         DRAIN: begin
            if (out_ready) begin
               if (row_addr_q == LAST_ROW) begin
                  state_d = FRAME_END;
               end else begin
                  state_d    = ISSUE;
                  row_addr_d = row_addr_q + RWIDTH'(1);
               end
            end
         end
         FRAME_END: begin
            gen_count_d = gen_count_q + GWIDTH'(1);
            row_addr_d  = '0;
            state_d     = (run && !step_mode_q) ? ISSUE : IDLE;
`ifdef GEN_LIMIT_EN
            if (limit_stop) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      // A clear beats a same-cycle increment.
      if (clear_gen) gen_count_d = '0;
   end

   // State and counter registers; a reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         row_addr_q  <= '0;
         gen_count_q <= '0;
         step_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_addr_q  <= row_addr_d;
         gen_count_q <= gen_count_d;
         step_mode_q <= step_mode_d;
      end
   end

   assign row_addr   = row_addr_q;
   assign gen_count  = gen_count_q;
   assign row_start  = (state_q == ISSUE);
   assign out_valid  = (state_q == DRAIN);
   assign frame_done = (state_q == FRAME_END);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conware_gen_sequencer.sv
// Directed bench for conware_gen_sequencer with HEIGHT=4.
// The compute engine and the packer are driven by hand, cycle by cycle.
// Outputs are sampled 1 time unit after each rising edge.
module tb_conware_gen_sequencer;
   localparam int HEIGHT = 4;
   localparam int RWIDTH = 8;
   localparam int GWIDTH = 16;

   logic              clk = 1'b0;
   logic              rst, run, step, clear_gen, row_done, out_ready;
   logic [RWIDTH-1:0] row_addr;
   logic              row_start, out_valid, frame_done, busy;
   logic [GWIDTH-1:0] gen_count;
`ifdef GEN_LIMIT_EN
   logic [GWIDTH-1:0] gen_limit;
   logic              limit_hit;
`endif

   int errors = 0;
   int checks = 0;
   int exp_gen = 0;

   always #5 clk = ~clk;

   conware_gen_sequencer #(.HEIGHT(HEIGHT), .RWIDTH(RWIDTH), .GWIDTH(GWIDTH)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .clear_gen(clear_gen),
      .row_addr(row_addr), .row_start(row_start), .row_done(row_done),
      .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
      .gen_count(gen_count), .busy(busy)
`ifdef GEN_LIMIT_EN
      , .gen_limit(gen_limit), .limit_hit(limit_hit)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called while in ISSUE for row r: checks the pulse, returns done one cycle later, and accepts the row.
   // Returns right after the handshake edge.
   task automatic do_row(input int r);
      check("issue_start", row_start, 1);
      check("issue_addr", row_addr, r);
      tick();                        // COMPUTE
      check("compute_nostart", row_start, 0);
      row_done = 1'b1;
      tick();                        // DRAIN
      row_done = 1'b0;
      check("drain_valid", out_valid, 1);
      check("drain_addr", row_addr, r);
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1; run = 0; step = 0; clear_gen = 0; row_done = 0; out_ready = 1;
`ifdef GEN_LIMIT_EN
      gen_limit = '0;
`endif
      tick(); tick();
      rst = 0;
      check("rst_busy", busy, 0);
      check("rst_addr", row_addr, 0);
      check("rst_gen", gen_count, 0);
      check("rst_start", row_start, 0);
      check("rst_valid", out_valid, 0);
      check("rst_fdone", frame_done, 0);

      // 1: single step runs one frame, then back to IDLE.
      step = 1; tick(); step = 0;
      check("t1_busy", busy, 1);
      for (int r = 0; r < HEIGHT; r++) do_row(r);
      check("t1_fdone", frame_done, 1);
      check("t1_gen_pre", gen_count, 0);
      tick();
      exp_gen = 1;
      check("t1_fdone_off", frame_done, 0);
      check("t1_gen", gen_count, exp_gen);
      check("t1_idle", busy, 0);
      check("t1_addr0", row_addr, 0);

      // clear_gen while idle.
      clear_gen = 1; tick(); clear_gen = 0;
      exp_gen = 0;
      check("clr_idle", gen_count, exp_gen);

      // 2: free run, run drops during row 2 of frame 4; frame 4 still completes.
      run = 1; tick();
      for (int f = 0; f < 4; f++) begin
         for (int r = 0; r < HEIGHT; r++) begin
            if (f == 3 && r == 2) run = 0;
            do_row(r);
         end
         check("t2_fdone", frame_done, 1);
         check("t2_gen_pre", gen_count, exp_gen);
         tick();
         exp_gen++;
         check("t2_gen", gen_count, exp_gen);
         check("t2_next_start", row_start, (f < 3) ? 1 : 0);
         check("t2_busy", busy, (f < 3) ? 1 : 0);
      end

      // 3: out_ready low for 5 cycles in DRAIN.
      step = 1; tick(); step = 0;
      out_ready = 0;
      check("t3_start", row_start, 1);
      tick();
      row_done = 1; tick(); row_done = 0;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", out_valid, 1);
         check("t3_hold_addr", row_addr, 0);
         check("t3_hold_nostart", row_start, 0);
         tick();
      end
      check("t3_still_valid", out_valid, 1);
      out_ready = 1; tick();
      for (int r = 1; r < HEIGHT; r++) do_row(r);
      check("t3_fdone", frame_done, 1);
      tick();
      exp_gen++;
      check("t3_gen", gen_count, exp_gen);
      check("t3_idle", busy, 0);

      // 4: row_done during IDLE and ISSUE is ignored.
      row_done = 1; tick();
      check("t4_idle_ign", busy, 0);
      step = 1; tick(); step = 0;      // ISSUE, row_done still high
      check("t4_issue", row_start, 1);
      tick();                          // COMPUTE; the stale done was seen only in ISSUE
      row_done = 0;
      check("t4_compute_wait", out_valid, 0);
      tick();
      check("t4_compute_wait2", out_valid, 0);
      check("t4_compute_busy", busy, 1);
      check("t4_compute_nostart", row_start, 0);
      row_done = 1; tick(); row_done = 0;
      check("t4_drain", out_valid, 1);
      tick();                          // handshake -> ISSUE row 1
      do_row(1);
      // 5: reset while COMPUTE of row 2.
      check("t5_issue2", row_addr, 2);
      tick();                          // COMPUTE row 2
      rst = 1; tick(); rst = 0;
      check("t5_busy", busy, 0);
      check("t5_addr", row_addr, 0);
      check("t5_gen", gen_count, 0);
      check("t5_start", row_start, 0);
      check("t5_valid", out_valid, 0);
      check("t5_fdone", frame_done, 0);
      row_done = 1; tick(); row_done = 0;
      check("t5_quiet", row_start | out_valid | frame_done | busy, 0);

`ifdef GEN_LIMIT_EN
      // 6: generation limit of 2 with run held high; clear_gen is applied in the final FRAME_END.
      gen_limit = 16'd2;
      run = 1; tick();
      for (int r = 0; r < HEIGHT; r++) do_row(r);
      check("t6_fdone1", frame_done, 1);
      check("t6_nolimit1", limit_hit, 0);
      tick();
      check("t6_cont", row_start, 1);
      check("t6_gen1", gen_count, 1);
      for (int r = 0; r < HEIGHT; r++) do_row(r);
      check("t6_fdone2", frame_done, 1);
      check("t6_limit", limit_hit, 1);
      clear_gen = 1; tick(); clear_gen = 0;
      check("t6_idle", busy, 0);
      check("t6_limit_off", limit_hit, 0);
      check("t6_gen_clr", gen_count, 0);
      run = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
